// File: rtl/error_accumulator_pkg.sv
// Shared regression constants and FSM encoding
// for the error accumulator slice.
package error_accumulator_pkg;

  localparam int N_SAMPLES_D = 150;
  localparam int DATA_W_D    = 20;
  localparam int ACC_W_D     = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/error_accumulator_if.sv
// Run control, sample stream and result bundle
// between a regression driver and the accumulator.
interface error_accumulator_if
  import error_accumulator_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int ACC_W  = ACC_W_D
);

  logic              start;
  logic              err_valid;
  logic [DATA_W-1:0] err_in;
  logic              ack;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  sse;
  logic [DATA_W-1:0] max_abs;
  logic [7:0]        sample_cnt;

  modport master (
    output start, err_valid, err_in, ack,
    input  busy, done, sse, max_abs, sample_cnt
  );

  modport slave (
    input  start, err_valid, err_in, ack,
    output busy, done, sse, max_abs, sample_cnt
  );

endinterface

// File: rtl/error_squarer.sv
// Combinational signed square of one error sample,
// returned as an unsigned 2*DATA_W magnitude.
module error_squarer
  import error_accumulator_pkg::*;
#(
  parameter int DATA_W = DATA_W_D
) (
  input  logic signed [DATA_W-1:0]   err,
  output logic        [2*DATA_W-1:0] sq
);

  logic signed [2*DATA_W-1:0] prod;

  // Full-width product: (-2^(W-1))^2 fits in 2W bits
  assign prod = err * err;
  assign sq   = $unsigned(prod);

endmodule

// File: rtl/error_accumulator.sv
// Sum-of-squares and peak |error| over one regression run,
// with a start / done / ack handshake.
module error_accumulator
  import error_accumulator_pkg::*;
#(
  parameter int N_SAMPLES = N_SAMPLES_D,
  parameter int DATA_W    = DATA_W_D,
  parameter int ACC_W     = ACC_W_D
) (
  input  logic                clk,
  input  logic                rst,
  error_accumulator_if.slave  bus
);

  localparam logic [7:0] LAST = 8'(N_SAMPLES - 1);

  acc_state_t        state;
  logic              busy_q;
  logic              done_q;
  logic [ACC_W-1:0]  sse_q;
  logic [DATA_W-1:0] max_q;
  logic [7:0]        cnt_q;

  logic signed [DATA_W-1:0] err_s;
  logic [2*DATA_W-1:0]      sq;
  logic [DATA_W-1:0]        abs_v;

  assign err_s = $signed(bus.err_in);

  error_squarer #(
    .DATA_W (DATA_W)
  ) u_sq (
    .err (err_s),
    .sq  (sq)
  );

  // Negating the most negative value leaves the bit
  // pattern 2^(W-1), which is the right unsigned magnitude
  assign abs_v = err_s[DATA_W-1] ? $unsigned(-err_s)
                                 : $unsigned(err_s);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sse_q  <= '0;
      max_q  <= '0;
      cnt_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= ACCUM;
            busy_q <= 1'b1;
            sse_q  <= '0;
            max_q  <= '0;
            cnt_q  <= '0;
          end
        end
        ACCUM: begin
          if (bus.err_valid) begin
            sse_q <= sse_q + ACC_W'(sq);
            cnt_q <= cnt_q + 8'd1;
            if (abs_v > max_q) max_q <= abs_v;
            if (cnt_q == LAST) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.ack) begin
            state  <= IDLE;
            done_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.sse        = sse_q;
  assign bus.max_abs    = max_q;
  assign bus.sample_cnt = cnt_q;

endmodule

// File: tb/tb_error_accumulator.sv
// Directed bench for error_accumulator: run table
// plus reset, handshake and ignored-event sequences.
module tb_error_accumulator;
  import error_accumulator_pkg::*;

  logic clk;
  logic rst;

  error_accumulator_if bus ();

  error_accumulator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [19:0] a;
    logic signed [19:0] b;
    int                 gap;
    int                 start_at;
    bit                 lead_valid;
    logic [47:0]        exp_sse;
    logic [19:0]        exp_max;
  } vec_t;

  vec_t vecs[5];
  int   tests;
  int   fails;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check({tag, "_sse"}, 64'(bus.sse), 64'd0);
    check({tag, "_max"}, 64'(bus.max_abs), 64'd0);
    check({tag, "_cnt"}, 64'(bus.sample_cnt), 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    int k;
    bit valid;
    logic [47:0] p_sse;
    logic [7:0]  p_cnt;
    logic [19:0] p_max;
    string tag;
    tag = $sformatf("v%0d", idx);
    bus.start     = 1'b1;
    bus.err_valid = v.lead_valid;
    bus.err_in    = 20'd100;
    tick();
    bus.start = 1'b0;
    check({tag, "_start_busy"}, 64'(bus.busy), 64'd1);
    check({tag, "_start_sse"}, 64'(bus.sse), 64'd0);
    check({tag, "_start_cnt"}, 64'(bus.sample_cnt), 64'd0);
    n = 0;
    k = 0;
    while (n < 150 && k < 1000) begin
      valid = !(v.gap > 0 && (k % v.gap) == v.gap - 1);
      bus.err_valid = valid;
      bus.err_in    = (n % 2 == 0) ? v.a : v.b;
      bus.start     = (valid && n == v.start_at);
      p_sse = bus.sse;
      p_cnt = bus.sample_cnt;
      p_max = bus.max_abs;
      tick();
      bus.start = 1'b0;
      if (!valid) begin
        check({tag, "_gap_sse"}, 64'(bus.sse), 64'(p_sse));
        check({tag, "_gap_cnt"}, 64'(bus.sample_cnt), 64'(p_cnt));
        check({tag, "_gap_max"}, 64'(bus.max_abs), 64'(p_max));
      end else begin
        n++;
      end
      k++;
    end
    bus.err_valid = 1'b0;
    if (k >= 1000)
      check({tag, "_budget"}, 64'(k), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_sse"}, 64'(bus.sse), 64'(v.exp_sse));
    check({tag, "_max"}, 64'(bus.max_abs), 64'(v.exp_max));
    check({tag, "_cnt"}, 64'(bus.sample_cnt), 64'd150);
  endtask

  task automatic ack_start(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    bus.ack   = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.ack   = 1'b0;
    bus.start = 1'b0;
    check({tag, "_ack_done"}, 64'(bus.done), 64'd0);
    check({tag, "_ack_busy"}, 64'(bus.busy), 64'd0);
    tick();
    check({tag, "_nolatch_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_idle_sse"}, 64'(bus.sse), 64'(v.exp_sse));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.err_valid = 1'b0;
    bus.err_in    = '0;
    bus.ack       = 1'b0;

    vecs[0] = '{20'sd3, 20'sd3, 0, -1, 1'b0,
                48'd1350, 20'd3};
    vecs[1] = '{-20'sd5, 20'sd4, 3, -1, 1'b1,
                48'd3075, 20'd5};
    vecs[2] = '{-20'sd524288, -20'sd524288, 0, -1, 1'b0,
                48'd41231686041600, 20'd524288};
    vecs[3] = '{20'sd1, -20'sd1, 0, 70, 1'b1,
                48'd150, 20'd1};
    vecs[4] = '{20'sd524287, 20'sd524287, 2, -1, 1'b0,
                48'd41231528755350, 20'd524287};

    tick();
    tick();
    check_zero("por");
    rst = 1'b1;

    // err_valid and ack while idle must not disturb anything
    bus.err_valid = 1'b1;
    bus.err_in    = 20'd77;
    bus.ack       = 1'b1;
    tick();
    tick();
    bus.err_valid = 1'b0;
    bus.ack       = 1'b0;
    check_zero("idle_ign");

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], i);
      if (i == 0) begin
        for (int c = 0; c < 10; c++) begin
          bus.start     = (c % 2 == 0);
          bus.err_valid = 1'b1;
          bus.err_in    = 20'd9;
          tick();
          check("hold_done", 64'(bus.done), 64'd1);
          check("hold_sse", 64'(bus.sse), 64'd1350);
          check("hold_cnt", 64'(bus.sample_cnt), 64'd150);
        end
        bus.start     = 1'b0;
        bus.err_valid = 1'b0;
      end
      ack_start(vecs[i], i);
    end

    // reset in the middle of an accumulation run
    bus.start = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.err_valid = 1'b1;
    bus.err_in    = 20'd6;
    for (int c = 0; c < 5; c++) tick();
    check("pre_rst_cnt", 64'(bus.sample_cnt), 64'd5);
    rst = 1'b0;
    tick();
    check_zero("rst_acc1");
    tick();
    check_zero("rst_acc2");
    rst = 1'b1;
    tick();
    check_zero("rst_acc_idle");
    bus.err_valid = 1'b0;

    // reset while holding a finished result
    run_vec(vecs[0], 9);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_zero("rst_done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
